// File: rtl/egd_pkg.sv
// Shared definitions for the Exp-Golomb stream decoder: request modes,
// FSM states and default widths.
package egd_pkg;

  typedef enum logic [1:0] {
    EGD_UE = 2'b00,
    EGD_SE = 2'b01,
    EGD_TE = 2'b10,
    EGD_UN = 2'b11
  } egd_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_HOLD   = 2'b10
  } egd_state_e;

  localparam int EGD_IN_W   = 16;
  localparam int EGD_OUT_W  = 16;
  localparam int EGD_MAX_LZ = 15;

endpackage

// File: rtl/egd_lzc.sv
// Leading-zero counter over a left-aligned window, limited to the first
// i_level bits; o_all_zero means no 1 was found inside the valid bits.
module egd_lzc #(
  parameter int BUF_W = 32,
  parameter int LVL_W = $clog2(BUF_W + 1)
) (
  input  logic [BUF_W-1:0] i_buf,
  input  logic [LVL_W-1:0] i_level,
  output logic [LVL_W-1:0] o_lz,
  output logic             o_all_zero
);

  logic [LVL_W-1:0] w_clz;

  // NOTE: every signal driven from always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    w_clz = LVL_W'(BUF_W);
    for (int i = 0; i < BUF_W; i++) begin
      if (i_buf[i]) w_clz = LVL_W'(BUF_W - 1 - i);
    end
  end

  assign o_all_zero = (w_clz >= i_level);
  assign o_lz       = o_all_zero ? i_level : w_clz;

endmodule

// File: rtl/egd_stream_decoder.sv
// H.264 ue/se/te/u(n) syntax-element decoder over a 2*IN_W-bit bitstream
// buffer, refilled by a valid/ready word port and drained per request.
module egd_stream_decoder
  import egd_pkg::*;
#(
  parameter int IN_W   = EGD_IN_W,
  parameter int OUT_W  = EGD_OUT_W,
  parameter int MAX_LZ = EGD_MAX_LZ
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [IN_W-1:0]                bs_data,
  input  logic                           bs_valid,
  output logic                           bs_ready,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_mode,
  input  logic [4:0]                     req_len,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [OUT_W-1:0]               res_value,
  output logic [5:0]                     res_bits,
  output logic                           res_err,
  output logic [$clog2(2*IN_W+1)-1:0]    buf_level
);

  localparam int BUF_W = 2 * IN_W;
  localparam int LVL_W = $clog2(BUF_W + 1);

  egd_state_e       r_state, w_state_next;
  egd_mode_e        r_mode;
  logic [4:0]       r_len;
  logic [BUF_W-1:0] r_buf, w_buf_next, w_top, w_k;
  logic [LVL_W-1:0] r_level, w_lvl_next, w_lvl_kept, w_consumed, w_lz;
  logic             w_all_zero, r_alive;
  logic [OUT_W-1:0] r_res_value, w_value;
  logic [5:0]       r_res_bits, w_bits;
  logic             r_res_err, w_err, w_done, w_req_fire, w_push;

  function automatic logic [BUF_W-1:0] f_top(input logic [BUF_W-1:0] data, input int n);
    f_top = (n == 0) ? '0 : data >> (BUF_W - n);
  endfunction

  egd_lzc #(.BUF_W(BUF_W), .LVL_W(LVL_W)) u_lzc (
    .i_buf      (r_buf),
    .i_level    (r_level),
    .o_lz       (w_lz),
    .o_all_zero (w_all_zero)
  );

  // The top 2*LZ+1 bits read as a number are 2^LZ + info, so k is that minus one.
  always_comb begin : p_decode
    int need;
    int lz_i;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_bits  = '0;
    w_value = '0;
    w_top   = '0;
    w_k     = '0;
    need    = 0;
    lz_i    = int'(w_lz);
    if (r_state == ST_DECODE) begin
      if (r_mode == EGD_UN || (r_mode == EGD_TE && r_len == 5'd1)) begin
        need = (r_mode == EGD_UN) ? int'(r_len) : 1;
        if (int'(r_level) >= need) begin
          w_done  = 1'b1;
          w_bits  = 6'(need);
          w_top   = f_top(r_buf, need);
          w_value = (r_mode == EGD_UN) ? OUT_W'(w_top) : OUT_W'(!w_top[0]);
        end
      end else if (lz_i > MAX_LZ) begin
        w_done = 1'b1;
        w_err  = 1'b1;
        w_bits = 6'(MAX_LZ + 1);
      end else if (!w_all_zero && int'(r_level) >= 2 * lz_i + 1) begin
        need   = 2 * lz_i + 1;
        w_done = 1'b1;
        w_bits = 6'(need);
        w_top  = f_top(r_buf, need);
        w_k    = w_top - BUF_W'(1);
        if (r_mode == EGD_SE)
          w_value = w_k[0] ? OUT_W'((w_k + BUF_W'(1)) >> 1) : OUT_W'(-(w_k >> 1));
        else
          w_value = OUT_W'(w_k);
      end
    end
  end

  // Consumption is removed first; a pushed word lands right after what remains.
  assign w_req_fire = req_valid && req_ready;
  assign w_push     = bs_valid && bs_ready;
  assign w_consumed = LVL_W'(w_bits);
  assign w_lvl_kept = r_level - w_consumed;
  assign w_buf_next = (r_buf << w_consumed)
                    | (w_push ? ({bs_data, {IN_W{1'b0}}} >> w_lvl_kept) : '0);
  assign w_lvl_next = w_lvl_kept + (w_push ? LVL_W'(IN_W) : '0);

  // NOTE: registered state is always updated with non-blocking assignments
  // so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_state <= ST_IDLE;
    else if (flush) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_req_fire) w_state_next = ST_DECODE;
      ST_DECODE: if (w_done)     w_state_next = ST_HOLD;
      ST_HOLD:   if (res_ready)  w_state_next = ST_IDLE;
      default:                   w_state_next = ST_IDLE;
    endcase
  end

  // r_alive keeps the ready outputs low until the first edge after reset.
  always_comb begin
    req_ready = r_alive && (r_state == ST_IDLE);
    res_valid = (r_state == ST_HOLD);
    bs_ready  = r_alive && (r_level <= LVL_W'(BUF_W - IN_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive     <= 1'b0;
      r_buf       <= '0;
      r_level     <= '0;
      r_mode      <= EGD_UE;
      r_len       <= '0;
      r_res_value <= '0;
      r_res_bits  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (flush) begin
        r_buf       <= '0;
        r_level     <= '0;
        r_mode      <= EGD_UE;
        r_len       <= '0;
        r_res_value <= '0;
        r_res_bits  <= '0;
        r_res_err   <= 1'b0;
      end else begin
        r_buf   <= w_buf_next;
        r_level <= w_lvl_next;
        if (w_req_fire) begin
          r_mode <= egd_mode_e'(req_mode);
          r_len  <= req_len;
        end
        if (w_done) begin
          r_res_value <= w_value;
          r_res_bits  <= w_bits;
          r_res_err   <= w_err;
        end
      end
    end
  end

  assign res_value = r_res_value;
  assign res_bits  = r_res_bits;
  assign res_err   = r_res_err;
  assign buf_level = r_level;

endmodule

// File: tb/tb_egd_stream_decoder.sv
// Self-checking bench: bit-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_egd_stream_decoder;
  import egd_pkg::*;

  localparam int IN_W   = 16;
  localparam int BUF_W  = 32;
  localparam int MAX_LZ = 15;
  localparam int M_IDLE = 0, M_DECODE = 1, M_HOLD = 2;

  logic        clk, reset_n, flush;
  logic [15:0] bs_data;
  logic        bs_valid, bs_ready, req_valid, req_ready;
  logic [1:0]  req_mode;
  logic [4:0]  req_len;
  logic        res_valid, res_ready, res_err;
  logic [15:0] res_value;
  logic [5:0]  res_bits, buf_level;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  egd_stream_decoder dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_len(req_len),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_bits(res_bits), .res_err(res_err), .buf_level(buf_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: buffer as a queue of bits ----------------
  bit          m_q[$];
  int          m_state = M_IDLE;
  bit          m_alive = 0;
  logic [1:0]  m_mode  = 2'b00;
  int          m_len   = 0;
  logic [15:0] m_value = '0;
  int          m_bits  = 0;
  bit          m_err   = 0;

  function automatic void m_decode(input logic [1:0] mode, input int len, output bit ok,
                                   output logic [15:0] value, output int nbits, output bit err);
    int z, k, info;
    ok = 0; value = '0; nbits = 0; err = 0;
    if (mode == EGD_UN) begin
      if (m_q.size() >= len) begin
        ok = 1; nbits = len;
        for (int i = 0; i < len; i++) value = {value[14:0], m_q[i]};
      end
    end else if (mode == EGD_TE && len == 1) begin
      if (m_q.size() >= 1) begin
        ok = 1; nbits = 1; value = m_q[0] ? 16'd0 : 16'd1;
      end
    end else begin
      z = 0;
      while (z < m_q.size() && z <= MAX_LZ && m_q[z] == 1'b0) z++;
      if (z > MAX_LZ) begin
        ok = 1; err = 1; nbits = MAX_LZ + 1;
      end else if (z < m_q.size() && m_q.size() >= 2 * z + 1) begin
        info = 0;
        for (int i = 0; i < z; i++) info = info * 2 + int'(m_q[z + 1 + i]);
        k = (1 << z) - 1 + info;
        ok = 1; nbits = 2 * z + 1;
        if (mode == EGD_SE) value = (k % 2 == 1) ? 16'((k + 1) / 2) : 16'(-(k / 2));
        else                value = 16'(k);
      end
    end
  endfunction

  initial forever begin : model
    bit          push, fire, ok, e;
    logic [15:0] v;
    int          nb;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_q.delete(); m_state = M_IDLE; m_alive = 0; m_value = '0; m_bits = 0; m_err = 0;
    end else if (flush) begin
      m_q.delete(); m_state = M_IDLE; m_alive = 1; m_value = '0; m_bits = 0; m_err = 0;
    end else begin
      push = bs_valid && m_alive && (m_q.size() <= BUF_W - IN_W);
      fire = req_valid && m_alive && (m_state == M_IDLE);
      m_alive = 1;
      case (m_state)
        M_IDLE: if (fire) begin
          m_mode = req_mode; m_len = int'(req_len); m_state = M_DECODE;
        end
        M_DECODE: begin
          m_decode(m_mode, m_len, ok, v, nb, e);
          if (ok) begin
            m_value = v; m_bits = nb; m_err = e;
            repeat (nb) void'(m_q.pop_front());
            m_state = M_HOLD;
          end
        end
        default: if (res_ready) m_state = M_IDLE;
      endcase
      if (push) for (int i = IN_W - 1; i >= 0; i--) m_q.push_back(bs_data[i]);
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (cmp_en) begin
      check("res_valid", res_valid, m_state == M_HOLD);
      check("req_ready", req_ready, m_alive && m_state == M_IDLE);
      check("bs_ready", bs_ready, m_alive && m_q.size() <= BUF_W - IN_W);
      check("buf_level", buf_level, m_q.size());
      if (m_state == M_HOLD) begin
        check("res_value", res_value, m_value);
        check("res_bits", res_bits, m_bits);
        check("res_err", res_err, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    bit done = 0;
    bs_data = w; bs_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = bs_ready;
      tick();
    end
    bs_valid = 1'b0;
    check("push_timeout", done, 1);
  endtask

  task automatic request(input logic [1:0] mode, input logic [4:0] len);
    bit done = 0;
    req_mode = mode; req_len = len; req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check("req_timeout", done, 1);
  endtask

  task automatic wait_res();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (res_valid) seen = 1;
      else tick();
    end
    check("res_timeout", seen, 1);
  endtask

  task automatic accept();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n = 1'b1; flush = 1'b0; bs_valid = 1'b0; bs_data = '0;
    req_valid = 1'b0; req_mode = '0; req_len = '0; res_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 cmp_en = 1;
    tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_bs_ready", bs_ready, 0);
    check("rst_level", buf_level, 0);
    check("rst_value", res_value, 0);
    repeat (2) tick();
    #3 reset_n = 1'b1;
    tick();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_bs_ready", bs_ready, 1);

    // ue(v) on 00111...
    push_word(16'h3800); request(EGD_UE, 0); wait_res();
    check("ue_value", res_value, 6);
    check("ue_bits", res_bits, 5);
    check("ue_level", buf_level, 11);
    accept();

    // se(v) on the same word, then ue on 1...
    do_flush();
    check("flush_level", buf_level, 0);
    push_word(16'h3800); request(EGD_SE, 0); wait_res();
    check("se_value", res_value, 16'hFFFD);
    check("se_bits", res_bits, 5);
    accept();
    do_flush();
    push_word(16'h8000); request(EGD_UE, 0); wait_res();
    check("ue0_value", res_value, 0);
    check("ue0_bits", res_bits, 1);
    accept();

    // te cMax=1 then u(5) on 0101 1000...
    do_flush();
    push_word(16'h5800); request(EGD_TE, 1); wait_res();
    check("te_value", res_value, 1);
    check("te_bits", res_bits, 1);
    accept();
    request(EGD_UN, 5); wait_res();
    check("u5_value", res_value, 22);
    check("u5_bits", res_bits, 5);
    accept();
    request(EGD_UN, 0); wait_res();
    check("u0_value", res_value, 0);
    check("u0_bits", res_bits, 0);
    accept();

    // stall on an empty buffer, then error on 16 zeros
    do_flush();
    request(EGD_UE, 0);
    repeat (3) begin tick(); check("stall_no_valid", res_valid, 0); end
    push_word(16'h0000);
    check("stall_after_first_push", res_valid, 0);
    push_word(16'h8001);
    check("err_valid", res_valid, 1);
    check("err_flag", res_err, 1);
    check("err_bits", res_bits, 16);
    check("err_value", res_value, 0);
    check("err_level", buf_level, 16);
    accept();
    request(EGD_UE, 0); wait_res();
    check("after_err_value", res_value, 0);
    check("after_err_err", res_err, 0);
    accept();

    // push concurrent with consume at level 16, then backpressure on the result
    do_flush();
    push_word(16'h3800); request(EGD_UE, 0);
    bs_data = 16'h1234; bs_valid = 1'b1; tick(); bs_valid = 1'b0;
    check("conc_valid", res_valid, 1);
    check("conc_level", buf_level, 16 - 5 + 16);
    check("conc_bs_ready", bs_ready, 0);
    repeat (5) begin
      tick();
      check("bp_value", res_value, 6);
      check("bp_bits", res_bits, 5);
      check("bp_req_ready", req_ready, 0);
    end
    accept();

    // flush while in DECODE drops the request
    do_flush();
    request(EGD_UE, 0);
    do_flush();
    check("fl_level", buf_level, 0);
    check("fl_req_ready", req_ready, 1);
    repeat (2) begin tick(); check("fl_no_valid", res_valid, 0); end

    // asynchronous reset while in HOLD
    push_word(16'h3800); request(EGD_SE, 0); wait_res();
    #2 reset_n = 1'b0;
    #1;
    check("arst_res_valid", res_valid, 0);
    check("arst_value", res_value, 0);
    check("arst_bits", res_bits, 0);
    check("arst_level", buf_level, 0);
    check("arst_req_ready", req_ready, 0);
    #3 reset_n = 1'b1;
    tick();

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      bs_valid = ($urandom_range(0, 99) < 40);
      case ($urandom_range(0, 3))
        0:       bs_data = 16'($urandom);
        1:       bs_data = 16'h0000;
        2:       bs_data = 16'(1 << $urandom_range(0, 15));
        default: bs_data = 16'($urandom) >> $urandom_range(0, 15);
      endcase
      req_valid = ($urandom_range(0, 99) < 50);
      req_mode  = 2'($urandom_range(0, 3));
      req_len   = (req_mode == EGD_UN) ? 5'($urandom_range(0, 16)) : 5'($urandom_range(1, 4));
      res_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 199) == 0);
      tick();
    end
    bs_valid = 1'b0; req_valid = 1'b0; res_ready = 1'b1; flush = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
